window_3x3_stream: RTL and testbench

- Streaming 3x3 neighbourhood generator placed between the grayscale stage and the Sobel operator.
- Accepts one 8-bit gray pixel per handshake, in raster order (row-major, top-left first).
- Keeps the two previous image rows in line buffers and emits one 3x3 window for every interior pixel.
- Lets the Sobel stage run at one pixel per clock without holding the whole frame in memory.

---
 rtl/sobel_pkg.sv | 29 ++
 rtl/window_3x3_stream_if.sv | 26 ++
 rtl/line_ram_sp.sv | 26 ++
 rtl/window_3x3_stream.sv | 105 ++++++++++
 tb/tb_window_3x3_stream.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel front end: pixel and 3x3 window types,
// window element indices (k = 3*row + col), and frame geometry defaults.
package sobel_pkg;

  localparam int PIX_W      = 8;
  localparam int DEF_WIDTH  = 160;
  localparam int DEF_HEIGHT = 120;
  localparam int COORD_W    = 16;

  localparam int W_TL = 0;
  localparam int W_T  = 1;
  localparam int W_TR = 2;
  localparam int W_L  = 3;
  localparam int W_C  = 4;
  localparam int W_R  = 5;
  localparam int W_BL = 6;
  localparam int W_B  = 7;
  localparam int W_BR = 8;

  typedef logic [PIX_W-1:0]   pix_t;
  typedef logic [COORD_W-1:0] coord_t;
  // Element k occupies bits [PIX_W*k +: PIX_W].
  typedef logic [8:0][PIX_W-1:0] window_t;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/window_3x3_stream_if.sv
// Pixel-in / window-out handshake bundle. The slave side is the window generator
// and the master side is whoever feeds pixels and consumes windows.
interface window_3x3_stream_if;
  import sobel_pkg::*;

  logic    in_valid;
  logic    in_ready;
  pix_t    in_pixel;
  logic    out_valid;
  logic    out_ready;
  window_t out_window;
  coord_t  out_x;
  coord_t  out_y;
  logic    frame_done;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_x, out_y, frame_done
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, out_x, out_y, frame_done
  );

endinterface

// File: rtl/line_ram_sp.sv
// Single-port line RAM, synchronous write with combinational read, one access per cycle.
// A write returns the old contents on rdata_o in the same cycle (read-before-write).
module line_ram_sp
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_WIDTH,
  parameter int AW    = addr_bits(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pix_t          wdata_i,
  output pix_t          rdata_o
);

  pix_t mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window_3x3_stream.sv
// Raster pixel stream to 3x3 windows for interior pixels; window valid one cycle after
// the completing accept. Single output register: in_ready = !out_valid || out_ready.
module window_3x3_stream
  import sobel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                clk,
  input  logic                rst,
  window_3x3_stream_if.slave  s
);

  localparam int AW = addr_bits(WIDTH);

  coord_t  col_q, col_d, row_q, row_d;
  coord_t  x_q, x_d, y_q, y_d;
  logic    vld_q, vld_d;
  logic    done_q, done_d;
  window_t win_q, win_d;
  pix_t    line0_rd, line1_rd;
  logic    accept, last_col, last_row, emit;

  assign s.in_ready = !rst && (!vld_q || s.out_ready);
  assign accept     = s.in_valid && s.in_ready;
  assign last_col   = (col_q == COORD_W'(WIDTH - 1));
  assign last_row   = (row_q == COORD_W'(HEIGHT - 1));
  assign emit       = (row_q >= COORD_W'(2)) && (col_q >= COORD_W'(2));

  // line0 holds row r-1, line1 holds row r-2; both shift down one row on each accept.
  line_ram_sp #(.DEPTH(WIDTH), .AW(AW)) u_line0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q[AW-1:0]),
    .wdata_i (s.in_pixel),
    .rdata_o (line0_rd)
  );

  line_ram_sp #(.DEPTH(WIDTH), .AW(AW)) u_line1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q[AW-1:0]),
    .wdata_i (line0_rd),
    .rdata_o (line1_rd)
  );

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    x_d    = x_q;
    y_d    = y_q;
    vld_d  = vld_q;
    win_d  = win_q;
    done_d = 1'b0;
    if (accept) begin
      col_d  = last_col ? '0 : col_q + COORD_W'(1);
      if (last_col) begin
        row_d = last_row ? '0 : row_q + COORD_W'(1);
      end
      done_d = last_col && last_row;
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[W_TR] = line1_rd;
      win_d[W_R]  = line0_rd;
      win_d[W_BR] = s.in_pixel;
      // Columns 0 and 1 only flush the previous row out of the shift register.
      vld_d = emit;
      if (emit) begin
        x_d = col_q - COORD_W'(1);
        y_d = row_q - COORD_W'(1);
      end
    end else if (s.out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      win_q  <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      x_q    <= x_d;
      y_q    <= y_d;
      vld_q  <= vld_d;
      done_q <= done_d;
      win_q  <= win_d;
    end
  end

  assign s.out_valid  = vld_q;
  assign s.out_window = win_q;
  assign s.out_x      = x_q;
  assign s.out_y      = y_q;
  assign s.frame_done = done_q;

endmodule

// File: tb/tb_window_3x3_stream.sv
// Scoreboard bench for window_3x3_stream on a 5x4 frame: a frame-image model predicts
// windows on every accept, and a negedge monitor pops and compares each delivered window.
module tb_window_3x3_stream;
  import sobel_pkg::*;

  localparam int W = 5;
  localparam int H = 4;

  typedef struct {
    window_t w;
    coord_t  x;
    coord_t  y;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_3x3_stream_if bus ();

  window_3x3_stream #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  pix_t  img [H][W];
  int    ar = 0;
  int    ac = 0;
  logic  done_exp = 1'b0;
  int    done_cnt = 0;
  int    rdy_mode = 0;
  item_t exp_q [$];
  item_t got_q [$];
  item_t ref_q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, expected event did not occur", nm);
  endtask

  // Window whose top-left pixel value is b, for a frame where pixel = r*W + c + offset.
  function automatic window_t mk(input int b);
    window_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[3*i+j] = pix_t'(b + W*i + j);
    return w;
  endfunction

  // Monitor and reference model: frame image indexed by (row, col) of each accepted pixel.
  item_t g, e;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      ar = 0;
      ac = 0;
      done_exp = 1'b0;
    end else begin
      chk("frame_done", 128'(bus.frame_done), 128'(done_exp));
      if (bus.frame_done) done_cnt++;
      done_exp = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        g.w = bus.out_window;
        g.x = bus.out_x;
        g.y = bus.out_y;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got x=%0d y=%0d, expected no window", g.x, g.y);
        end else begin
          e = exp_q.pop_front();
          chk("window", 128'(g.w), 128'(e.w));
          chk("out_x", 128'(g.x), 128'(e.x));
          chk("out_y", 128'(g.y), 128'(e.y));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        img[ar][ac] = bus.in_pixel;
        if (ar >= 2 && ac >= 2) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.w[3*i+j] = img[ar-2+i][ac-2+j];
          e.x = coord_t'(ac - 1);
          e.y = coord_t'(ar - 1);
          exp_q.push_back(e);
        end
        if (ac == W - 1) begin
          ac = 0;
          if (ar == H - 1) begin
            ar = 0;
            done_exp = 1'b1;
          end else begin
            ar++;
          end
        end else begin
          ac++;
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after `limit` pixels have been accepted.
  task automatic send_frame(input int base, input int gap, input int limit);
    int   n;
    int   t;
    logic acc;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < limit) begin
          if (gap != 0 && $urandom_range(0, 1) == 1) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk);
              #1;
            end
          end
          bus.in_valid = 1'b1;
          bus.in_pixel = pix_t'(r*W + c + base);
          t = 0;
          do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
          end while (!acc && t < 500);
          if (!acc) fail("accept_timeout");
          n++;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) fail("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_frame_done", 128'(bus.frame_done), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic bp_check();
    int      t;
    window_t cw;
    coord_t  cx, cy;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.out_valid && t < 200);
    if (!bus.out_valid) begin
      fail("bp_wait_valid");
    end else begin
      cw = bus.out_window;
      cx = bus.out_x;
      cy = bus.out_y;
      chk("bp_first_window", 128'(cw), 128'(mk(0)));
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
        chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
        chk("bp_window_hold", 128'(bus.out_window), 128'(cw));
        chk("bp_x_hold", 128'(bus.out_x), 128'(cx));
        chk("bp_y_hold", 128'(bus.out_y), 128'(cy));
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_out_window", 128'(bus.out_window), 128'(0));
    chk("reset_out_x", 128'(bus.out_x), 128'(0));
    chk("reset_out_y", 128'(bus.out_y), 128'(0));
    chk("reset_frame_done", 128'(bus.frame_done), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Continuous stream, always ready.
    got_q.delete();
    done_cnt = 0;
    send_frame(0, 0, W*H);
    drain();
    chk("s1_count", 128'(got_q.size()), 128'(6));
    chk("s1_done_count", 128'(done_cnt), 128'(1));
    if (got_q.size() == 6) begin
      chk("s1_first_window", 128'(got_q[0].w), 128'(mk(0)));
      chk("s1_first_x", 128'(got_q[0].x), 128'(1));
      chk("s1_first_y", 128'(got_q[0].y), 128'(1));
      chk("s1_row_boundary_window", 128'(got_q[3].w), 128'(mk(5)));
      chk("s1_last_window", 128'(got_q[5].w), 128'(mk(7)));
      chk("s1_last_x", 128'(got_q[5].x), 128'(3));
      chk("s1_last_y", 128'(got_q[5].y), 128'(2));
    end
    ref_q = got_q;

    // Backpressure: first window held for five cycles.
    got_q.delete();
    rdy_mode = 2;
    fork
      send_frame(0, 0, W*H);
      bp_check();
    join
    rdy_mode = 0;
    drain();
    chk("bp_count", 128'(got_q.size()), 128'(6));

    // Gapped input with random downstream stalls.
    got_q.delete();
    rdy_mode = 1;
    send_frame(0, 1, W*H);
    rdy_mode = 0;
    drain();
    chk("gap_count", 128'(got_q.size()), 128'(ref_q.size()));
    for (int k = 0; k < got_q.size() && k < ref_q.size(); k++)
      chk("gap_same_window", 128'(got_q[k].w), 128'(ref_q[k].w));

    // Reset after 12 accepts, then a clean frame.
    send_frame(0, 0, 12);
    do_reset();
    got_q.delete();
    done_cnt = 0;
    send_frame(0, 0, W*H);
    drain();
    chk("rst_count", 128'(got_q.size()), 128'(ref_q.size()));
    chk("rst_done_count", 128'(done_cnt), 128'(1));
    for (int k = 0; k < got_q.size() && k < ref_q.size(); k++) begin
      chk("rst_same_window", 128'(got_q[k].w), 128'(ref_q[k].w));
      chk("rst_same_x", 128'(got_q[k].x), 128'(ref_q[k].x));
    end

    // Two frames back to back, second offset by 100.
    got_q.delete();
    done_cnt = 0;
    send_frame(0, 0, W*H);
    send_frame(100, 0, W*H);
    drain();
    chk("b2b_count", 128'(got_q.size()), 128'(12));
    chk("b2b_done_count", 128'(done_cnt), 128'(2));
    if (got_q.size() == 12) begin
      chk("b2b_f2_first_window", 128'(got_q[6].w), 128'(mk(100)));
      chk("b2b_f2_first_x", 128'(got_q[6].x), 128'(1));
      chk("b2b_f2_first_y", 128'(got_q[6].y), 128'(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
